// File: rtl/ofddr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofddr_pkg
// Purpose  : Shared definitions for the DDR output register. Holds the
//            alignment-mode codes and the string-to-code mapping applied to
//            the DDR_ALIGNMENT parameter at elaboration.
// Revision : 1.0 - initial release
// ============================================================================
package ofddr_pkg;

  localparam logic [1:0] ALIGN_NONE      = 2'd0;
  localparam logic [1:0] ALIGN_SAME_EDGE = 2'd1;
  // Returned for any unrecognised mode string; the top refuses to elaborate
  // when it sees this code.
  localparam logic [1:0] ALIGN_INVALID   = 2'd3;

  function automatic logic [1:0] align_from_str(input string name);
    if (name == "NONE") begin
      return ALIGN_NONE;
    end else if (name == "SAME_EDGE") begin
      return ALIGN_SAME_EDGE;
    end
    return ALIGN_INVALID;
  endfunction

endpackage : ofddr_pkg
`default_nettype wire

// File: rtl/ofddr_rse_bit.sv
`default_nettype none
// ============================================================================
// Module   : ofddr_rse_bit
// Purpose  : One bit of the DDR output register. r0 captures on the rising
//            edge and r1 on the falling edge; q shows r0 while clk is high
//            and r1 while clk is low. In SAME_EDGE mode d1 is staged in p1
//            on the rising edge and moved into r1 on the next falling edge.
// Ports    : clk  - clock (rise = C0 phase, fall = C1 phase)
//            rst  - synchronous active-high reset, acts at both edges
//            s    - synchronous active-high set, acts at both edges
//            ce   - capture enable
//            d0   - data shown in the high phase
//            d1   - data shown in the low phase
//            q    - DDR output
// Revision : 1.0 - initial release
// ============================================================================
module ofddr_rse_bit
  import ofddr_pkg::*;
#(
  parameter logic       INIT  = 1'b0,
  parameter logic [1:0] ALIGN = ALIGN_NONE
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic ce,
  input  logic d0,
  input  logic d1,
  output logic q
);

  // In NONE mode r1 samples d1 directly and honours ce. In SAME_EDGE mode
  // the ce gating already happened at p1, so the r1 transfer is unconditional
  // apart from rst/s.
  localparam logic R1_GATED = (ALIGN == ALIGN_NONE);

  logic r0_q = INIT;
  logic r1_q = INIT;
  logic r0_d;
  logic r1_d;
  logic r1_src;

  always_comb begin
    r0_d = r0_q;
    if (rst)      r0_d = 1'b0;
    else if (s)   r0_d = 1'b1;
    else if (ce)  r0_d = d0;
  end

  // rst/s/ce are combinational here, so the falling-edge flop sees the
  // levels present at the falling edge, independent of the rising edge.
  always_comb begin
    r1_d = r1_q;
    if (rst)                   r1_d = 1'b0;
    else if (s)                r1_d = 1'b1;
    else if (ce || !R1_GATED)  r1_d = r1_src;
  end

  always_ff @(posedge clk) begin
    r0_q <= r0_d;
  end

  always_ff @(negedge clk) begin
    r1_q <= r1_d;
  end

  generate
    if (ALIGN == ALIGN_SAME_EDGE) begin : g_same_edge
      logic p1_q = INIT;
      logic p1_d;

      always_comb begin
        p1_d = p1_q;
        if (rst)      p1_d = 1'b0;
        else if (s)   p1_d = 1'b1;
        else if (ce)  p1_d = d1;
      end

      always_ff @(posedge clk) begin
        p1_q <= p1_d;
      end

      assign r1_src = p1_q;
    end else begin : g_none
      assign r1_src = d1;
    end
  endgenerate

  // Output mux selected by clock level; the data flops only change on
  // edges, so there is no path from d0/d1 to q.
  assign q = clk ? r0_q : r1_q;

endmodule : ofddr_rse_bit
`default_nettype wire

// File: rtl/ofddr_rse.sv
`default_nettype none
// ============================================================================
// Module   : ofddr_rse
// Purpose  : WIDTH-bit DDR output register with synchronous reset, set and
//            clock enable, for pin-boundary use (GMII TX data, forwarded
//            clocks with d0=0/d1=1).
// Ports    : clk  - clock (rise = C0 phase, fall = C1 phase)
//            rst  - synchronous active-high reset, forces q low
//            s    - synchronous active-high set, forces q high
//            ce   - capture enable
//            d0   - [WIDTH] data shown while clk is high
//            d1   - [WIDTH] data shown while clk is low
//            q    - [WIDTH] DDR output
// Revision : 1.0 - initial release
// ============================================================================
module ofddr_rse
  import ofddr_pkg::*;
#(
  parameter int    WIDTH         = 1,
  parameter logic  INIT          = 1'b0,
  parameter string DDR_ALIGNMENT = "NONE"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             ce,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] ALIGN = align_from_str(DDR_ALIGNMENT);

  generate
    if (ALIGN == ALIGN_INVALID) begin : g_bad_align
      $error("ofddr_rse: DDR_ALIGNMENT must be \"NONE\" or \"SAME_EDGE\"");
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ofddr_rse_bit #(
        .INIT  (INIT),
        .ALIGN (ALIGN)
      ) u_bit (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .ce  (ce),
        .d0  (d0[i]),
        .d1  (d1[i]),
        .q   (q[i])
      );
    end
  endgenerate

endmodule : ofddr_rse
`default_nettype wire

// File: tb/tb_ofddr_rse.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofddr_rse
// Purpose  : Self-checking bench for ofddr_rse. Three instances share one
//            clock: a 1-bit NONE instance with INIT=1 (power-up and clock
//            forwarding), an 8-bit NONE instance (data, priority, enable,
//            mid-stream reset) and an 8-bit SAME_EDGE instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofddr_rse;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit, NONE, INIT=1
  logic       rst_a = 1'b0, s_a = 1'b0, ce_a = 1'b0;
  logic [0:0] d0_a = '0, d1_a = '0, q_a;
  // 8-bit, NONE
  logic       rst_b = 1'b0, s_b = 1'b0, ce_b = 1'b0;
  logic [7:0] d0_b = '0, d1_b = '0, q_b;
  // 8-bit, SAME_EDGE
  logic       rst_c = 1'b0, s_c = 1'b0, ce_c = 1'b0;
  logic [7:0] d0_c = '0, d1_c = '0, q_c;

  ofddr_rse #(.WIDTH(1), .INIT(1'b1), .DDR_ALIGNMENT("NONE")) u_a (
    .clk(clk), .rst(rst_a), .s(s_a), .ce(ce_a), .d0(d0_a), .d1(d1_a), .q(q_a));
  ofddr_rse #(.WIDTH(8), .INIT(1'b0), .DDR_ALIGNMENT("NONE")) u_b (
    .clk(clk), .rst(rst_b), .s(s_b), .ce(ce_b), .d0(d0_b), .d1(d1_b), .q(q_b));
  ofddr_rse #(.WIDTH(8), .INIT(1'b0), .DDR_ALIGNMENT("SAME_EDGE")) u_c (
    .clk(clk), .rst(rst_c), .s(s_c), .ce(ce_c), .d0(d0_c), .d1(d1_c), .q(q_c));

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t x;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Sample 2 time units after each edge, well clear of the next one.
  task automatic wait_rise();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fall();
    @(negedge clk);
    #2;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Power-up value before any edge.
    #1;
    push("powerup_init1", 8'h01);
    check({7'b0, q_a});
    push("powerup_init0", 8'h00);
    check(q_b);

    // First rising edge with rst high.
    push("reset_rise_a", 8'h00);
    push("reset_rise_b", 8'h00);
    wait_rise();
    check({7'b0, q_a});
    check(q_b);

    // Reset held through the falling edge as well.
    push("reset_fall_a", 8'h00);
    wait_fall();
    check({7'b0, q_a});

    // Clock forwarding: q must be the complement of clk on every phase.
    rst_a = 1'b0; ce_a = 1'b1; d0_a = 1'b0; d1_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push("clkfwd_high", 8'h00);
      wait_rise();
      check({7'b0, q_a});
      push("clkfwd_low", 8'h01);
      wait_fall();
      check({7'b0, q_a});
    end

    // Data path, NONE mode.
    rst_b = 1'b0; ce_b = 1'b1; d0_b = 8'hA5; d1_b = 8'h3C;
    push("data_high", 8'hA5);
    wait_rise();
    check(q_b);
    push("data_low", 8'h3C);
    wait_fall();
    check(q_b);

    // rst and s together: reset wins.
    rst_b = 1'b1; s_b = 1'b1;
    push("prio_rst_over_s", 8'h00);
    wait_rise();
    check(q_b);
    rst_b = 1'b0;
    push("set_fall", 8'hFF);
    wait_fall();
    check(q_b);
    push("set_rise", 8'hFF);
    wait_rise();
    check(q_b);

    // Establish 11/22 alternation.
    s_b = 1'b0; d0_b = 8'h11; d1_b = 8'h22;
    push("ce_fill_low", 8'h22);
    wait_fall();
    check(q_b);
    push("ce_fill_high", 8'h11);
    wait_rise();
    check(q_b);
    push("ce_fill_low2", 8'h22);
    wait_fall();
    check(q_b);

    // ce low: new data must not appear, output keeps toggling.
    ce_b = 1'b0; d0_b = 8'h77; d1_b = 8'h88;
    for (int i = 0; i < 3; i++) begin
      push("ce_hold_high", 8'h11);
      wait_rise();
      check(q_b);
      push("ce_hold_low", 8'h22);
      wait_fall();
      check(q_b);
    end

    // Reset raised in the high phase takes effect at the falling edge.
    wait_rise();
    rst_b = 1'b1;
    push("rst_midstream_fall", 8'h00);
    wait_fall();
    check(q_b);
    // Released with ce low: r0 still holds 11, r1 stays at its reset 0.
    rst_b = 1'b0;
    push("rst_release_high", 8'h11);
    wait_rise();
    check(q_b);
    push("rst_release_low", 8'h00);
    wait_fall();
    check(q_b);

    // SAME_EDGE: d1 is captured at the rising edge; a later change is ignored.
    rst_c = 1'b0; ce_c = 1'b1; d0_c = 8'h01; d1_c = 8'h02;
    push("same_edge_high", 8'h01);
    wait_rise();
    check(q_c);
    d1_c = 8'hFF;
    push("same_edge_low", 8'h02);
    wait_fall();
    check(q_c);
    push("same_edge_high2", 8'h01);
    wait_rise();
    check(q_c);
    push("same_edge_low2", 8'hFF);
    wait_fall();
    check(q_c);

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ofddr_rse
`default_nettype wire
